// File: rtl/somador_serial_nbits_if.sv
// -----------------------------------------------------------------------------
// somador_serial_nbits_if
// Handshake and operand/result bundle for the serial adder/subtractor.
//   master : controller side, drives start/Sub/A/B/Cin and observes results
//   slave  : adder side, samples the request and drives S/Cout/Ovf/busy/done
// -----------------------------------------------------------------------------
interface somador_serial_nbits_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, Sub, A, B, Cin,
        input  S, Cout, Ovf, busy, done
    );

    modport slave (
        input  start, Sub, A, B, Cin,
        output S, Cout, Ovf, busy, done
    );
endinterface

// File: rtl/somador_serial_nbits.sv
// -----------------------------------------------------------------------------
// somador_serial_nbits
// Multi-cycle WIDTH-bit adder/subtractor. Each clock adds BPC bits with a
// chained full-adder slice; the carry is kept in a register between chunks,
// so an operation takes N = WIDTH/BPC clocks from the accepting edge to done.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of somador_serial_nbits_if
//          start/Sub/A/B/Cin in; S/Cout/Ovf (held until next done), busy, done
// -----------------------------------------------------------------------------
module somador_serial_nbits #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    somador_serial_nbits_if.slave bus
);
    localparam int N     = WIDTH / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_param
            $error("somador_serial_nbits: BPC must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;      // operand A, shifted right each chunk
    logic [WIDTH-1:0] b_q, b_d;      // B or ~B, shifted right each chunk
    logic [WIDTH-1:0] acc_q, acc_d;  // partial sum, filled from the MSB side
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Chunk adder: c[i] is the carry into bit i of the current chunk.
    logic [BPC:0]     c;
    logic [BPC-1:0]   chunk_s;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        c       = '0;
        chunk_s = '0;
        c[0]    = carry_q;
        for (int i = 0; i < BPC; i++) begin
            chunk_s[i] = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]     = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
        // New chunk enters at the top; after N chunks the LSB chunk has
        // travelled down to bit 0 and acc holds the full sum.
        acc_next = (acc_q >> BPC) | (WIDTH'(chunk_s) << (WIDTH - BPC));
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1; Cin is ignored in that mode.
                    a_d     = bus.A;
                    b_d     = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Sub ? 1'b1 : bus.Cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = c[BPC];
                acc_d   = acc_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    s_d     = acc_next;
                    cout_d  = c[BPC];
                    // Signed overflow: carry into MSB differs from carry out.
                    ovf_d   = c[BPC] ^ c[BPC-1];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    // NOTE: the datapath registers are reset too, so an aborted operation
    // leaves no stale operand or carry behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
    assign bus.busy = (state_q == CALC);
    assign bus.done = done_q;

endmodule

// File: tb/tb_somador_serial_nbits.sv
// -----------------------------------------------------------------------------
// tb_somador_serial_nbits
// Drives three 8-bit instances (BPC = 1, 4, 8) with shared operands and
// per-instance start lines, and compares results, latency and handshake
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_somador_serial_nbits;
    localparam int W = 8;
    localparam int BPCS[3] = '{1, 4, 8};
    localparam int NS[3]   = '{8, 2, 1};

    logic         clk;
    logic         rst;
    logic [2:0]   start_v;
    logic         sub_r;
    logic         cin_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;

    logic [W-1:0] s_o[3];
    logic         cout_o[3];
    logic         ovf_o[3];
    logic         busy_o[3];
    logic         done_o[3];

    int n_tests = 0;
    int n_fail  = 0;

    somador_serial_nbits_if #(.WIDTH(W)) bus0 ();
    somador_serial_nbits_if #(.WIDTH(W)) bus1 ();
    somador_serial_nbits_if #(.WIDTH(W)) bus2 ();

    somador_serial_nbits #(.WIDTH(W), .BPC(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    somador_serial_nbits #(.WIDTH(W), .BPC(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    somador_serial_nbits #(.WIDTH(W), .BPC(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.Sub = sub_r;  assign bus1.Sub = sub_r;  assign bus2.Sub = sub_r;
    assign bus0.Cin = cin_r;  assign bus1.Cin = cin_r;  assign bus2.Cin = cin_r;
    assign bus0.A   = a_r;    assign bus1.A   = a_r;    assign bus2.A   = a_r;
    assign bus0.B   = b_r;    assign bus1.B   = b_r;    assign bus2.B   = b_r;

    assign s_o[0] = bus0.S;       assign s_o[1] = bus1.S;       assign s_o[2] = bus2.S;
    assign cout_o[0] = bus0.Cout; assign cout_o[1] = bus1.Cout; assign cout_o[2] = bus2.Cout;
    assign ovf_o[0] = bus0.Ovf;   assign ovf_o[1] = bus1.Ovf;   assign ovf_o[2] = bus2.Ovf;
    assign busy_o[0] = bus0.busy; assign busy_o[1] = bus1.busy; assign busy_o[2] = bus2.busy;
    assign done_o[0] = bus0.done; assign done_o[1] = bus1.done; assign done_o[2] = bus2.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the two's-complement operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         ovf;
        bb  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
        return {ovf, sum[W], sum[W-1:0]};
    endfunction

    // One operation on all three instances; checks latency, pulse width,
    // busy duration and the held results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string tag);
        int done_cyc[3];
        int done_cnt[3];
        int busy_cnt[3];
        @(negedge clk);
        a_r = a; b_r = b; cin_r = cin; sub_r = sub; start_v = 3'b111;
        @(negedge clk);
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            done_cyc[i] = -1; done_cnt[i] = 0; busy_cnt[i] = 0;
        end
        for (int cyc = 0; cyc <= 9; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy_o[i]) busy_cnt[i]++;
                if (done_o[i]) begin
                    done_cnt[i]++;
                    if (done_cyc[i] < 0) done_cyc[i] = cyc;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s bpc%0d latency", tag, BPCS[i]), 32'(done_cyc[i]), 32'(NS[i]));
            check($sformatf("%s bpc%0d done_width", tag, BPCS[i]), 32'(done_cnt[i]), 32'd1);
            check($sformatf("%s bpc%0d busy_cycles", tag, BPCS[i]), 32'(busy_cnt[i]), 32'(NS[i]));
            check($sformatf("%s bpc%0d S", tag, BPCS[i]), 32'(s_o[i]), 32'(es));
            check($sformatf("%s bpc%0d Cout", tag, BPCS[i]), 32'(cout_o[i]), 32'(ec));
            check($sformatf("%s bpc%0d Ovf", tag, BPCS[i]), 32'(ovf_o[i]), 32'(eo));
        end
    endtask

    // Waits (bounded) for done on the BPC=1 instance.
    task automatic wait_done0(input string tag);
        int found;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_o[0]) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           ndone;

        tbl[0] = '{a: 8'd200, b: 8'd100, cin: 1'b0, sub: 1'b0, s: 8'd44,  cout: 1'b1, ovf: 1'b0};
        tbl[1] = '{a: 8'd100, b: 8'd100, cin: 1'b0, sub: 1'b0, s: 8'd200, cout: 1'b0, ovf: 1'b1};
        tbl[2] = '{a: 8'd255, b: 8'd0,   cin: 1'b1, sub: 1'b0, s: 8'd0,   cout: 1'b1, ovf: 1'b0};
        tbl[3] = '{a: 8'd5,   b: 8'd7,   cin: 1'b0, sub: 1'b1, s: 8'd254, cout: 1'b0, ovf: 1'b0};
        tbl[4] = '{a: 8'd5,   b: 8'd7,   cin: 1'b1, sub: 1'b1, s: 8'd254, cout: 1'b0, ovf: 1'b0};
        tbl[5] = '{a: 8'd128, b: 8'd1,   cin: 1'b0, sub: 1'b1, s: 8'd127, cout: 1'b1, ovf: 1'b1};

        rst = 1'b1; start_v = 3'b000; sub_r = 1'b0; cin_r = 1'b0; a_r = '0; b_r = '0;
        #23 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset bpc%0d S", BPCS[i]), 32'(s_o[i]), 32'd0);
            check($sformatf("reset bpc%0d busy", BPCS[i]), 32'(busy_o[i]), 32'd0);
            check($sformatf("reset bpc%0d done", BPCS[i]), 32'(done_o[i]), 32'd0);
            check($sformatf("reset bpc%0d Cout_Ovf", BPCS[i]), 32'({cout_o[i], ovf_o[i]}), 32'd0);
        end

        for (int t = 0; t < 6; t++)
            run_op(tbl[t].a, tbl[t].b, tbl[t].cin, tbl[t].sub,
                   tbl[t].s, tbl[t].cout, tbl[t].ovf, $sformatf("vec%0d", t));

        // start pulsed 3 cycles into CALC must be ignored, with no queuing
        @(negedge clk);
        a_r = 8'd200; b_r = 8'd100; cin_r = 1'b0; sub_r = 1'b0; start_v = 3'b001;
        @(negedge clk);
        start_v = 3'b000;
        repeat (3) @(negedge clk);
        a_r = 8'd1; b_r = 8'd1; start_v = 3'b001;
        @(negedge clk);
        start_v = 3'b000;
        wait_done0("ignore");
        check("ignore S", 32'(s_o[0]), 32'd44);
        check("ignore Cout", 32'(cout_o[0]), 32'd1);
        @(negedge clk);
        check("ignore no_requeue busy", 32'(busy_o[0]), 32'd0);

        // start in the done cycle is accepted; old S held until new done
        @(negedge clk);
        a_r = 8'd100; b_r = 8'd100; sub_r = 1'b0; start_v = 3'b001;
        @(negedge clk);
        start_v = 3'b000;
        wait_done0("b2b first");
        check("b2b first S", 32'(s_o[0]), 32'd200);
        a_r = 8'd5; b_r = 8'd7; sub_r = 1'b1; start_v = 3'b001;
        @(negedge clk);
        start_v = 3'b000;
        check("b2b accepted busy", 32'(busy_o[0]), 32'd1);
        check("b2b S held early", 32'(s_o[0]), 32'd200);
        repeat (4) @(negedge clk);
        check("b2b S held mid", 32'(s_o[0]), 32'd200);
        wait_done0("b2b second");
        check("b2b second S", 32'(s_o[0]), 32'd254);
        check("b2b second Cout", 32'(cout_o[0]), 32'd0);
        check("b2b second Ovf", 32'(ovf_o[0]), 32'd0);

        // asynchronous reset 4 cycles into an operation
        @(negedge clk);
        a_r = 8'd200; b_r = 8'd100; sub_r = 1'b0; start_v = 3'b001;
        @(negedge clk);
        start_v = 3'b000;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst S", 32'(s_o[0]), 32'd0);
        check("async_rst busy", 32'(busy_o[0]), 32'd0);
        check("async_rst done", 32'(done_o[0]), 32'd0);
        check("async_rst Cout_Ovf", 32'({cout_o[0], ovf_o[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) ndone++;
        end
        check("async_rst no_resume", 32'(ndone), 32'd0);
        run_op(8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0, "after_rst");

        // randomized vectors against the arithmetic model
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            m  = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, m[W-1:0], m[W], m[W+1], $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/somador_serial_nbits.md
Name: somador_serial_nbits

Overview:
- Multi-cycle, parametrised adder/subtractor for WIDTH-bit operands.
- Processes BPC bits per clock using a chained full-adder slice, ripple-style over WIDTH/BPC cycles.
- Carry is held in a register between chunks.
- Start/busy/done handshake to a controlling FSM; result, carry-out and signed overflow are registered and held until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits; WIDTH >= 1.
- BPC, 1, bits added per clock; 1 <= BPC <= WIDTH; WIDTH % BPC == 0 (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- Sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1, Cin ignored).
- A  input  WIDTH  operand A, sampled on accepting edge.
- B  input  WIDTH  operand B, sampled on accepting edge.
- Cin  input  1  carry-in, sampled on accepting edge.
- S  output  WIDTH  registered result.
- Cout  output  1  registered carry-out of MSB (Sub=1: 1 = no borrow).
- Ovf  output  1  registered two's-complement overflow.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result just updated.

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; S=0, Cout=0, Ovf=0, busy=0, done=0; internal shift registers, chunk counter and carry register cleared; in-flight operation discarded, no done.
- N = WIDTH/BPC chunks.
- States:
  - IDLE: busy=0.
  - CALC: busy=1.
- IDLE, start=1 at edge k:
  - latch A, B' (B, or ~B when Sub=1), carry register (Cin, or 1 when Sub=1), Sub.
  - counter=0, busy=1 after edge k.
- CALC, each edge:
  - add low BPC bits of A and B' plus the carry register.
  - shift the sum chunk into the result register from the MSB side; update carry; shift A and B' right by BPC; counter++.
- On the edge where the final chunk is processed (edge k+N):
  - S <= full sum; Cout <= final carry; Ovf <= carry into MSB XOR carry out of MSB.
  - busy <= 0, done <= 1; state IDLE.
- done is high exactly one cycle (k+N to k+N+1).
- Latency: accept edge to done edge is N clocks; WIDTH=8, BPC=1: 8; BPC=8: 1.
- S/Cout/Ovf change only on the done edge or reset; they hold the previous result during CALC.
- start while busy=1 is ignored, with no queuing. Input changes during CALC have no effect.
- Back-to-back: start=1 in the cycle done=1 is accepted (busy=0), giving throughput of one result per N+1 cycles minimum. The new result does not disturb the old S until its own done edge.
- Arithmetic is modulo 2^WIDTH.
- WIDTH=1, BPC=1: equals a registered 1-bit full adder with 1-cycle latency.
- start held high continuously: a new operation is accepted each time busy falls.

Test Plan:
- WIDTH=8, BPC=1, Sub=0, A=200, B=100, Cin=0 -> done exactly 8 cycles after accept; S=44, Cout=1, Ovf=0; busy high for 8 cycles.
- Sub=0, A=100, B=100, Cin=0 -> S=200, Cout=0, Ovf=1. Then A=255, B=0, Cin=1 -> S=0, Cout=1, Ovf=0.
- Sub=1 (Cin=0 and Cin=1 both) with A=5, B=7 -> S=254, Cout=0, Ovf=0. Sub=1, A=128, B=1 -> S=127, Cout=1, Ovf=1.
- BPC=4 and BPC=8 rerun of the above vectors -> identical results; done 2 and 1 cycles after accept respectively; randomized 1000 vectors per config compared against a reference model.
- Start pulsed again 3 cycles into CALC with different operands -> ignored; first result unchanged. Start asserted in the done cycle -> accepted; S keeps the old value until the new done.
- rst asserted asynchronously 4 cycles into an operation (between clock edges) -> outputs 0 immediately, busy=0, no done pulse. A fresh start after release -> correct result after N cycles.
